// File: rtl/hamming_decoder.sv
// ---------------------------------------------------------------------------
// hamming_decoder
//
// Single-error-correcting decoder for a word made of BLOCKS independent
// Hamming(7,4) blocks. Block i carries data d = in_data[4i+3:4i] and parity
// p = in_parity[3i+2:3i], where the encoder produced
//   p2 = d0^d2^d3,  p1 = d0^d1^d3,  p0 = d0^d1^d2.
// The syndrome (recomputed parity XOR received parity) selects which single
// bit of the block to flip; a zero syndrome leaves the block untouched.
//
// Two-stage valid/ready pipeline:
//   S1 registers the raw codeword.
//   S2 registers the corrected codeword (drives out_*).
// Backpressure propagates combinationally through in_ready, so the pipeline
// sustains one word per cycle while out_ready stays high.
//
// Optional feature (macro HAMMING_DECODER_ERRCNT_EN):
//   When defined, two saturating counters track words that needed a data-bit
//   correction (data_err_cnt) and words that needed only parity-bit
//   corrections (par_err_cnt). cnt_clr clears both synchronously and wins
//   over a same-cycle increment. When undefined, both counters read 0 and
//   cnt_clr is ignored.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous, active-high reset
//   in_valid     input codeword valid
//   in_ready     decoder accepts codeword
//   in_data      received data bits        [WIDTH-1:0]
//   in_parity    received parity bits      [PBITS-1:0]
//   out_valid    corrected word valid
//   out_ready    downstream accepts word
//   out_data     corrected data            [WIDTH-1:0]
//   out_parity   corrected parity          [PBITS-1:0]
//   out_corr     per-block correction flag [BLOCKS-1:0]
//   cnt_clr      synchronous clear of error counters
//   data_err_cnt words with at least one data-bit correction
//   par_err_cnt  words with parity-only corrections
// ---------------------------------------------------------------------------
module hamming_decoder #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned BLOCKS = WIDTH / 4,
  parameter int unsigned PBITS  = BLOCKS * 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [PBITS-1:0]  in_parity,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [PBITS-1:0]  out_parity,
  output logic [BLOCKS-1:0] out_corr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  data_err_cnt,
  output logic [CNT_W-1:0]  par_err_cnt
);

  // -------------------------------------------------------------------------
  // Pipeline state
  // -------------------------------------------------------------------------
  logic              s1_valid;
  logic [WIDTH-1:0]  s1_data;
  logic [PBITS-1:0]  s1_parity;
  logic              s2_valid;

  logic              s2_ready;
  logic              in_fire;
  logic              s1_move;
  logic              out_fire;

  // -------------------------------------------------------------------------
  // Syndrome and correction, computed from the S1 register
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0]  fix_data;
  logic [PBITS-1:0]  fix_par;
  logic [BLOCKS-1:0] fix_flag;
  logic [BLOCKS-1:0] blk_data_err;
  logic              any_data_err;
  logic              any_corr;

  for (genvar g = 0; g < BLOCKS; g++) begin : g_blk
    logic [3:0] d;
    logic [2:0] p;
    logic [2:0] s;
    logic [3:0] dfix;
    logic [2:0] pfix;

    assign d = s1_data[4*g +: 4];
    assign p = s1_parity[3*g +: 3];
    assign s = {d[0] ^ d[2] ^ d[3],
                d[0] ^ d[1] ^ d[3],
                d[0] ^ d[1] ^ d[2]} ^ p;

    // Each data bit feeds a distinct pair/triple of parity equations, so the
    // syndrome pattern names the erroneous bit; a one-hot syndrome means the
    // parity bit itself was hit.
    always_comb begin
      dfix = d;
      pfix = p;
      case (s)
        3'b111:  dfix[0] = ~d[0];
        3'b011:  dfix[1] = ~d[1];
        3'b101:  dfix[2] = ~d[2];
        3'b110:  dfix[3] = ~d[3];
        3'b100:  pfix[2] = ~p[2];
        3'b010:  pfix[1] = ~p[1];
        3'b001:  pfix[0] = ~p[0];
        default: ;
      endcase
    end

    assign fix_data[4*g +: 4] = dfix;
    assign fix_par[3*g +: 3]  = pfix;
    assign fix_flag[g]        = |s;
    assign blk_data_err[g]    = (s == 3'b111) || (s == 3'b011) ||
                                (s == 3'b101) || (s == 3'b110);
  end

  assign any_data_err = |blk_data_err;
  assign any_corr     = |fix_flag;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  assign out_valid = s2_valid;
  assign s2_ready  = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_ready;
  assign in_fire   = in_valid && in_ready;
  assign s1_move   = s1_valid && s2_ready;
  assign out_fire  = s2_valid && out_ready;

  // S1: raw codeword capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_parity <= '0;
    end else begin
      if (in_fire) begin
        s1_valid  <= 1'b1;
        s1_data   <= in_data;
        s1_parity <= in_parity;
      end else if (s1_move) begin
        s1_valid  <= 1'b0;
      end
    end
  end

  // S2: corrected word; held while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      out_data   <= '0;
      out_parity <= '0;
      out_corr   <= '0;
    end else begin
      if (s1_move) begin
        s2_valid   <= 1'b1;
        out_data   <= fix_data;
        out_parity <= fix_par;
        out_corr   <= fix_flag;
      end else if (out_fire) begin
        s2_valid   <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Error counters
  // -------------------------------------------------------------------------
`ifdef HAMMING_DECODER_ERRCNT_EN
  // A word is classified once, on its S1->S2 move. Any data-bit fix marks it
  // as a data error even if parity bits were also fixed in other blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_err_cnt <= '0;
      par_err_cnt  <= '0;
    end else if (cnt_clr) begin
      data_err_cnt <= '0;
      par_err_cnt  <= '0;
    end else if (s1_move) begin
      if (any_data_err) begin
        if (data_err_cnt != '1) data_err_cnt <= data_err_cnt + 1'b1;
      end else if (any_corr) begin
        if (par_err_cnt != '1) par_err_cnt <= par_err_cnt + 1'b1;
      end
    end
  end
`else
  assign data_err_cnt = '0;
  assign par_err_cnt  = '0;

  logic unused_cnt;
  assign unused_cnt = cnt_clr ^ any_data_err ^ any_corr;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// ---------------------------------------------------------------------------
// tb_hamming_decoder
//
// Scoreboard bench for hamming_decoder (WIDTH=8, two blocks, CNT_W=2).
// Stimulus builds a clean codeword from the encoder equations, then injects
// at most one bit error per block. The expected output is simply the clean
// codeword, the per-block "error injected" flags, and a word class derived
// from which kind of bit was injected. The driver pushes the expectation when
// the DUT accepts a word; an independent monitor pops and compares whenever a
// word leaves the DUT, checks that stalled outputs are held, and tracks the
// error counters.
// ---------------------------------------------------------------------------
module tb_hamming_decoder;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned BLOCKS = 2;
  localparam int unsigned PBITS  = 6;
  localparam int unsigned CNT_W  = 2;
  localparam int          CMAX   = 3;

`ifdef HAMMING_DECODER_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [PBITS-1:0]  in_parity;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [PBITS-1:0]  out_parity;
  logic [BLOCKS-1:0] out_corr;
  logic              cnt_clr;
  logic [CNT_W-1:0]  data_err_cnt;
  logic [CNT_W-1:0]  par_err_cnt;

  hamming_decoder #(
    .WIDTH (WIDTH),
    .BLOCKS(BLOCKS),
    .PBITS (PBITS),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_parity   (in_parity),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_parity  (out_parity),
    .out_corr    (out_corr),
    .cnt_clr     (cnt_clr),
    .data_err_cnt(data_err_cnt),
    .par_err_cnt (par_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cls: 0 = clean, 1 = parity-only errors, 2 = at least one data error
  typedef struct {
    logic [WIDTH-1:0]  data;
    logic [PBITS-1:0]  par;
    logic [BLOCKS-1:0] corr;
    int                cls;
  } exp_t;

  exp_t q[$];
  int   vectors      = 0;
  int   miscompares  = 0;
  int   cyc          = 0;
  int   acc_cnt      = 0;
  int   last_acc_cyc = 0;
  bit   rand_run     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] enc(input logic [3:0] d);
    return {d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d[0] ^ d[1] ^ d[2]};
  endfunction

  // codes per block: 0 none, 1..4 flip data bit code-1, 5..7 flip parity bit code-5
  function automatic logic [3*BLOCKS-1:0] rand_codes();
    logic [3*BLOCKS-1:0] c;
    for (int b = 0; b < BLOCKS; b++)
      c[3*b +: 3] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    return c;
  endfunction

  task automatic send(input logic [WIDTH-1:0] d, input logic [3*BLOCKS-1:0] codes);
    exp_t             e;
    logic [WIDTH-1:0] rd;
    logic [PBITS-1:0] rp;
    logic [2:0]       c;
    int               n;
    e.data = d;
    e.corr = '0;
    e.cls  = 0;
    for (int b = 0; b < BLOCKS; b++) e.par[3*b +: 3] = enc(d[4*b +: 4]);
    rd = d;
    rp = e.par;
    for (int b = 0; b < BLOCKS; b++) begin
      c = codes[3*b +: 3];
      if (c >= 3'd1 && c <= 3'd4) begin
        rd[4*b + int'(c) - 1] = ~rd[4*b + int'(c) - 1];
        e.corr[b] = 1'b1;
        e.cls     = 2;
      end else if (c >= 3'd5) begin
        rp[3*b + int'(c) - 5] = ~rp[3*b + int'(c) - 5];
        e.corr[b] = 1'b1;
        if (e.cls == 0) e.cls = 1;
      end
    end
    in_data   = rd;
    in_parity = rp;
    in_valid  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    check("send_accept", in_ready, 1'b1);
    if (in_ready) begin
      q.push_back(e);
      acc_cnt++;
      last_acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Output monitor / scoreboard
  // -------------------------------------------------------------------------
  logic              prev_v, prev_r, prev_clr, new_word;
  logic [WIDTH-1:0]  h_d;
  logic [PBITS-1:0]  h_p;
  logic [BLOCKS-1:0] h_c;
  int                m_d, m_p;
  exp_t              mon_e;

  initial begin
    prev_v = 1'b0; prev_r = 1'b0; prev_clr = 1'b0;
    m_d = 0; m_p = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0; prev_r = 1'b0; prev_clr = 1'b0;
        m_d = 0; m_p = 0;
        q.delete();
      end else begin
        if (prev_v && !prev_r)
          check("hold_stable", {out_valid, out_data, out_parity, out_corr},
                {1'b1, h_d, h_p, h_c});
        new_word = out_valid && (!prev_v || prev_r);
        if (new_word && q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got data %0h with no word outstanding", out_data);
        end
        if (prev_clr) begin
          m_d = 0;
          m_p = 0;
        end else if (new_word && q.size() != 0 && CNT_EN) begin
          if (q[0].cls == 2) begin
            if (m_d < CMAX) m_d++;
          end else if (q[0].cls == 1) begin
            if (m_p < CMAX) m_p++;
          end
        end
        check("data_err_cnt", data_err_cnt, m_d);
        check("par_err_cnt", par_err_cnt, m_p);
        if (out_valid && out_ready && q.size() != 0) begin
          mon_e = q.pop_front();
          check("out_data", out_data, mon_e.data);
          check("out_parity", out_parity, mon_e.par);
          check("out_corr", out_corr, mon_e.corr);
        end
        prev_v   = out_valid;
        prev_r   = out_ready;
        prev_clr = cnt_clr;
        h_d = out_data;
        h_p = out_parity;
        h_c = out_corr;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  int acc0, first_cyc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_data = '0; in_parity = '0;
    #7;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 0);
    check("rst_out_parity", out_parity, 0);
    check("rst_out_corr", out_corr, 0);
    check("rst_data_cnt", data_err_cnt, 0);
    check("rst_par_cnt", par_err_cnt, 0);
    #15 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;

    // Clean word, latency of two edges
    send(8'h0B, 6'o00);
    @(negedge clk);
    check("lat_not_yet", out_valid, 1'b0);
    @(negedge clk);
    check("clean_valid", out_valid, 1'b1);
    check("clean_data", out_data[3:0], 4'b1011);
    check("clean_parity", out_parity[2:0], 3'b010);
    check("clean_corr", out_corr, 0);
    check("clean_dcnt", data_err_cnt, 0);
    @(posedge clk); #1;

    // d2 flipped on the wire: 1011 -> 1111
    send(8'h0B, 6'o03);
    repeat (2) @(negedge clk);
    check("derr_data", out_data[3:0], 4'b1011);
    check("derr_corr", out_corr, 2'b01);
    check("derr_dcnt", data_err_cnt, CNT_EN ? 1 : 0);
    @(posedge clk); #1;

    // p2 flipped on the wire: 010 -> 110
    send(8'h0B, 6'o07);
    repeat (2) @(negedge clk);
    check("perr_parity", out_parity[2:0], 3'b010);
    check("perr_data", out_data[3:0], 4'b1011);
    check("perr_pcnt", par_err_cnt, CNT_EN ? 1 : 0);
    check("perr_dcnt", data_err_cnt, CNT_EN ? 1 : 0);
    @(posedge clk); #1;

    // Backpressure: two words fill the pipe, then in_ready must drop
    out_ready = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(8'(i * 37 + 5), (i == 1) ? 6'o03 : (i == 2) ? 6'o60 : 6'o00);
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_accepted", acc_cnt - acc0, 2);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Throughput: eight back-to-back words accepted on consecutive edges
    for (int i = 0; i < 8; i++) begin
      send(WIDTH'($urandom), rand_codes());
      if (i == 0) first_cyc = last_acc_cyc;
    end
    check("throughput", last_acc_cyc - first_cyc, 7);
    drain();

    // Saturation, then clear colliding with an increment
    for (int i = 0; i < 5; i++) send(8'hB4, 6'o30);
    drain();
    check("sat_dcnt", data_err_cnt, CNT_EN ? 3 : 0);
    cnt_clr = 1'b1;
    send(8'h0B, 6'o03);
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_prio_dcnt", data_err_cnt, 0);
    check("clr_prio_pcnt", par_err_cnt, 0);
    drain();

    // Randomized traffic with random stalls and clears
    rand_run = 1'b1;
    fork
      begin
        while (rand_run) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
          cnt_clr   = ($urandom_range(0, 40) == 0);
        end
      end
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send(WIDTH'($urandom), rand_codes());
        end
        rand_run = 1'b0;
      end
    join
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send(8'h5A, 6'o03);
    send(8'hC3, 6'o50);
    @(negedge clk);
    check("pre_rst_full", {out_valid, in_ready}, 2'b10);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_data", out_data, 0);
    check("async_rst_dcnt", data_err_cnt, 0);
    check("async_rst_pcnt", par_err_cnt, 0);
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("rel_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale", out_valid, 1'b0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) send(WIDTH'($urandom), rand_codes());
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
